stdp_update: RTL

- Spike-timing-dependent plasticity stage that sits downstream of the two LIF neurons.
- Consumes the presynaptic spike (lif1) and the postsynaptic spike (lif2).
- Tracks time since each neuron's last spike and updates a saturating synaptic weight on every pre/post pairing.
- Produces a weighted synaptic current (weight × pre spike) that can drive the postsynaptic neuron's input.

---
 rtl/stdp_update.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/stdp_update.sv
// STDP weight-update stage: pre/post spike timers, nearest-neighbour pairing,
// saturating weight and weighted current. Optional idle decay: STDP_WEIGHT_DECAY_EN.
module stdp_update #(
  parameter int WEIGHT_W     = 8,
  parameter int TRACE_W      = 4,
  parameter int WINDOW       = 15,
  parameter int W_INIT       = 16,
  parameter int W_MAX        = 255,
  parameter int W_MIN        = 0,
  parameter int A_PLUS       = 8,
  parameter int A_MINUS      = 8,
  parameter int DECAY_PERIOD = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pre_spike,
  input  logic                post_spike,
  input  logic                learn_en,
  output logic [WEIGHT_W-1:0] weight,
  output logic [WEIGHT_W-1:0] current_out,
  output logic                update_w_flag,
  output logic                ltp,
  output logic [TRACE_W-1:0]  time_diff
);

  localparam int                CW        = WEIGHT_W + 1;
  localparam logic [TRACE_W-1:0]  LP_WINDOW = TRACE_W'(WINDOW);
  localparam logic [WEIGHT_W-1:0] LP_W_INIT = WEIGHT_W'(W_INIT);

  logic [TRACE_W-1:0]  r_pre_timer, r_post_timer;
  logic                r_pre_valid, r_post_valid;
  logic [WEIGHT_W-1:0] r_weight, r_current;
  logic                r_flag, r_ltp;
  logic [TRACE_W-1:0]  r_time_diff;

  logic                w_ltp_hit, w_ltd_hit, w_update;
  logic [TRACE_W-1:0]  w_k, w_shift;
  logic [CW-1:0]       w_delta, w_sum;
  logic [WEIGHT_W-1:0] w_diff, w_stdp_weight, w_next_weight;

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_timer  <= '0;
      r_pre_valid  <= 1'b0;
      r_post_timer <= '0;
      r_post_valid <= 1'b0;
    end else begin
      if (pre_spike) begin
        r_pre_timer <= TRACE_W'(1);
        r_pre_valid <= 1'b1;
      end else if (r_pre_valid && r_pre_timer == LP_WINDOW) begin
        r_pre_valid <= 1'b0;
      end else if (r_pre_valid) begin
        r_pre_timer <= r_pre_timer + TRACE_W'(1);
      end

      if (post_spike) begin
        r_post_timer <= TRACE_W'(1);
        r_post_valid <= 1'b1;
      end else if (r_post_valid && r_post_timer == LP_WINDOW) begin
        r_post_valid <= 1'b0;
      end else if (r_post_valid) begin
        r_post_timer <= r_post_timer + TRACE_W'(1);
      end
    end
  end

  // A simultaneous pre/post spike is a restart of both timers, never a pairing.
  assign w_ltp_hit = learn_en && post_spike && !pre_spike && r_pre_valid;
  assign w_ltd_hit = learn_en && pre_spike && !post_spike && r_post_valid;
  assign w_update  = w_ltp_hit || w_ltd_hit;

  assign w_k     = w_ltp_hit ? r_pre_timer : r_post_timer;
  assign w_shift = (w_k - TRACE_W'(1)) >> 2;
  assign w_delta = w_ltp_hit ? CW'(A_PLUS >> w_shift) : CW'(A_MINUS >> w_shift);
  assign w_sum   = {1'b0, r_weight} + w_delta;
  assign w_diff  = r_weight - w_delta[WEIGHT_W-1:0];

  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    w_stdp_weight = r_weight;
    if (w_ltp_hit) begin
      w_stdp_weight = (w_sum > CW'(W_MAX)) ? WEIGHT_W'(W_MAX) : w_sum[WEIGHT_W-1:0];
    end else if (w_ltd_hit) begin
      w_stdp_weight = ({1'b0, r_weight} < w_delta + CW'(W_MIN)) ? WEIGHT_W'(W_MIN) : w_diff;
    end
  end

`ifdef STDP_WEIGHT_DECAY_EN
  localparam int IDLE_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

  logic [IDLE_W-1:0] r_idle;
  logic              w_decay_tick;

  assign w_decay_tick = !w_update && (r_idle == IDLE_W'(DECAY_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if (w_update || w_decay_tick) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + IDLE_W'(1);
    end
  end

  // Decay drifts one step toward the reset weight; STDP updates win the cycle.
  always_comb begin
    w_next_weight = w_stdp_weight;
    if (w_decay_tick) begin
      if (r_weight > LP_W_INIT)      w_next_weight = r_weight - WEIGHT_W'(1);
      else if (r_weight < LP_W_INIT) w_next_weight = r_weight + WEIGHT_W'(1);
    end
  end
`else
  assign w_next_weight = w_stdp_weight;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_weight    <= LP_W_INIT;
      r_current   <= '0;
      r_flag      <= 1'b0;
      r_ltp       <= 1'b0;
      r_time_diff <= '0;
    end else begin
      r_weight  <= w_next_weight;
      r_current <= pre_spike ? r_weight : '0;
      r_flag    <= w_update;
      if (w_update) begin
        r_ltp       <= w_ltp_hit;
        r_time_diff <= w_k;
      end
    end
  end

  assign weight        = r_weight;
  assign current_out   = r_current;
  assign update_w_flag = r_flag;
  assign ltp           = r_ltp;
  assign time_diff     = r_time_diff;

endmodule
